aib_bsr_scan_ctrl: RTL and testbench

AIB_BSR_SCAN_CTRL -- requirements
Module: aib_bsr_scan_ctrl

---
 rtl/aib_bsr_pkg.sv | 14 +
 rtl/aib_bsr_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_aib_bsr_scan_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/aib_bsr_pkg.sv
// Shared definitions for the AIB boundary-scan controller and its chain.
package aib_bsr_pkg;

  localparam int unsigned CHAIN_LEN_DEFAULT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StShift,
    StUpdate,
    StDone
  } bsr_state_e;

endpackage

// File: rtl/aib_bsr_scan_ctrl.sv
// Capture/shift/update sequencer for an aib_bsr_red_wrap boundary-scan chain.
// Every chain-facing control is a flop so the chain sees clean, glitch-free strobes.
module aib_bsr_scan_ctrl
  import aib_bsr_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 intest_req,
  input  logic                 release_req,
  input  logic                 rst_ovr_en,
  input  logic                 rst_ovr_val,
  input  logic [CHAIN_LEN-1:0] tx_data,
  input  logic                 jtag_rx_scan,
  output logic [CHAIN_LEN-1:0] rx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 jtag_tx_scanen,
  output logic                 jtag_clkdr,
  output logic                 jtag_tx_scan,
  output logic                 jtag_mode,
  output logic                 jtag_intest,
  output logic                 jtag_rstb_en,
  output logic                 jtag_rstb
);

  localparam int unsigned       CntW     = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0]   LastSlot = CntW'(CHAIN_LEN - 1);

  bsr_state_e           state_q, state_d;
  logic                 phase_q, phase_d;  // 0 = slot cycle A, 1 = slot cycle B
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] tx_q, tx_d;
  logic [CHAIN_LEN-1:0] rx_q, rx_d;
  logic                 intest_req_q, intest_req_d;
  logic                 mode_q, mode_d;
  logic                 intest_q, intest_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 scanen_q, scanen_d;
  logic                 clkdr_q, clkdr_d;
  logic                 tx_scan_q, tx_scan_d;
  logic                 rstb_en_q, rstb_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    intest_req_d = intest_req_q;
    mode_d       = mode_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StCapture;
          phase_d      = 1'b0;
          cnt_d        = '0;
          tx_d         = tx_data;
          intest_req_d = intest_req;
          mode_d       = 1'b1;
        end else if (release_req) begin
          mode_d = 1'b0;
        end
      end
      StCapture: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = StShift;
      end
      StShift: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          // Next MSB moves up once the current one is already on jtag_tx_scan.
          tx_d = CHAIN_LEN'({tx_q, 1'b0});
        end else begin
          rx_d = CHAIN_LEN'({rx_q, jtag_rx_scan});
          if (cnt_q == LastSlot) state_d = StUpdate;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      StUpdate: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it cycle-for-cycle.
    busy_d    = state_d inside {StCapture, StShift, StUpdate};
    done_d    = (state_d == StDone);
    scanen_d  = (state_d == StShift);
    clkdr_d   = ((state_d == StCapture) || (state_d == StShift)) && phase_d;
    tx_scan_d = tx_scan_q;
    if ((state_d == StShift) && !phase_d) tx_scan_d = tx_q[CHAIN_LEN-1];
    intest_d  = mode_d & intest_req_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      cnt_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      intest_req_q <= 1'b0;
      mode_q       <= 1'b0;
      intest_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      scanen_q     <= 1'b0;
      clkdr_q      <= 1'b0;
      tx_scan_q    <= 1'b0;
      rstb_en_q    <= 1'b0;
      rstb_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      intest_req_q <= intest_req_d;
      mode_q       <= mode_d;
      intest_q     <= intest_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      scanen_q     <= scanen_d;
      clkdr_q      <= clkdr_d;
      tx_scan_q    <= tx_scan_d;
      rstb_en_q    <= rst_ovr_en;
      rstb_q       <= rst_ovr_val;
    end
  end

  assign rx_data        = rx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign jtag_tx_scanen = scanen_q;
  assign jtag_clkdr     = clkdr_q;
  assign jtag_tx_scan   = tx_scan_q;
  assign jtag_mode      = mode_q;
  assign jtag_intest    = intest_q;
  assign jtag_rstb_en   = rstb_en_q;
  assign jtag_rstb      = rstb_q;

endmodule

// File: tb/tb_aib_bsr_scan_ctrl.sv
// Directed bench for aib_bsr_scan_ctrl driving a behavioural 4-cell scan chain.
module tb_aib_bsr_scan_ctrl;

  localparam int unsigned N = 4;

  // Per-cycle patterns over cycles 1..12 of an operation, bit (c-1) = cycle c.
  localparam logic [11:0] ExpDone   = 12'b1000_0000_0000;
  localparam logic [11:0] ExpBusy   = 12'b0111_1111_1111;
  localparam logic [11:0] ExpClkdr  = 12'b0010_1010_1010;
  localparam logic [11:0] ExpScanen = 12'b0011_1111_1100;
  localparam logic [11:0] ExpRbeOvr = 12'b1111_1110_0000;
  localparam logic [11:0] ExpRstOvr = 12'b0000_0001_1111;

  logic clk = 1'b0;
  logic rst, start, intest_req, release_req, rst_ovr_en, rst_ovr_val;
  logic [N-1:0] tx_data, rx_data;
  logic jtag_rx_scan;
  logic busy, done, jtag_tx_scanen, jtag_clkdr, jtag_tx_scan;
  logic jtag_mode, jtag_intest, jtag_rstb_en, jtag_rstb;

  int n_checks = 0;
  int n_pass   = 0;

  // Chain model: capture/shift on the rising strobe, scan-out changes on the falling one.
  logic [N-1:0] cells, cap_val;
  logic         rx_out;

  logic [11:0]  done_pat, busy_pat, clkdr_pat, scanen_pat, rbe_pat, rstb_pat;
  logic [N-1:0] tx_seen;
  logic         mode_c1;

  always #5 clk = ~clk;

  always @(posedge jtag_clkdr) begin
    if (jtag_tx_scanen) cells <= {cells[N-2:0], jtag_tx_scan};
    else                cells <= cap_val;
  end

  always @(negedge jtag_clkdr) rx_out <= cells[N-1];

  assign jtag_rx_scan = rx_out;

  aib_bsr_scan_ctrl #(.CHAIN_LEN(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .intest_req     (intest_req),
    .release_req    (release_req),
    .rst_ovr_en     (rst_ovr_en),
    .rst_ovr_val    (rst_ovr_val),
    .tx_data        (tx_data),
    .jtag_rx_scan   (jtag_rx_scan),
    .rx_data        (rx_data),
    .busy           (busy),
    .done           (done),
    .jtag_tx_scanen (jtag_tx_scanen),
    .jtag_clkdr     (jtag_clkdr),
    .jtag_tx_scan   (jtag_tx_scan),
    .jtag_mode      (jtag_mode),
    .jtag_intest    (jtag_intest),
    .jtag_rstb_en   (jtag_rstb_en),
    .jtag_rstb      (jtag_rstb)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start at edge 0 and record cycles 1..12; returns while in cycle 12.
  task automatic run_op(input logic [N-1:0] tx, input logic [N-1:0] cap, input logic intest,
                        input logic rel, input logic hold, input int ovr_cycle);
    tx_data     = tx;
    cap_val     = cap;
    intest_req  = intest;
    release_req = rel;
    start       = 1'b1;
    step();
    if (!hold) start = 1'b0;
    release_req = 1'b0;
    tx_seen     = '0;
    for (int c = 1; c <= 12; c++) begin
      done_pat[c-1]   = done;
      busy_pat[c-1]   = busy;
      clkdr_pat[c-1]  = jtag_clkdr;
      scanen_pat[c-1] = jtag_tx_scanen;
      rbe_pat[c-1]    = jtag_rstb_en;
      rstb_pat[c-1]   = jtag_rstb;
      if (c == 1) mode_c1 = jtag_mode;
      if (c == 3 || c == 5 || c == 7 || c == 9) tx_seen = {tx_seen[N-2:0], jtag_tx_scan};
      if (c == ovr_cycle) begin
        rst_ovr_en  = 1'b1;
        rst_ovr_val = 1'b0;
      end
      if (c < 12) step();
    end
  endtask

  task automatic check_timing(input string tag);
    check_eq($sformatf("%s.done", tag),   32'(done_pat),   32'(ExpDone));
    check_eq($sformatf("%s.busy", tag),   32'(busy_pat),   32'(ExpBusy));
    check_eq($sformatf("%s.clkdr", tag),  32'(clkdr_pat),  32'(ExpClkdr));
    check_eq($sformatf("%s.scanen", tag), 32'(scanen_pat), 32'(ExpScanen));
  endtask

  initial begin
    int k;
    rst         = 1'b1;
    start       = 1'b0;
    intest_req  = 1'b0;
    release_req = 1'b0;
    rst_ovr_en  = 1'b0;
    rst_ovr_val = 1'b1;
    tx_data     = '0;
    cap_val     = '0;
    cells       = '0;
    rx_out      = 1'b0;
    step();
    step();

    check_eq("rst.busy",    32'(busy),           'h0);
    check_eq("rst.done",    32'(done),           'h0);
    check_eq("rst.scanen",  32'(jtag_tx_scanen), 'h0);
    check_eq("rst.clkdr",   32'(jtag_clkdr),     'h0);
    check_eq("rst.mode",    32'(jtag_mode),      'h0);
    check_eq("rst.rstb_en", 32'(jtag_rstb_en),   'h0);
    check_eq("rst.rstb",    32'(jtag_rstb),      'h1);
    check_eq("rst.rx",      32'(rx_data),        'h0);
    #2 rst = 1'b0;
    step();

    // Basic EXTEST operation.
    run_op(4'b1011, 4'b0110, 1'b0, 1'b0, 1'b0, 0);
    check_timing("op1");
    check_eq("op1.tx_slots", 32'(tx_seen), 'hB);
    check_eq("op1.rx",       32'(rx_data), 'h6);
    check_eq("op1.chain",    32'(cells),   'hB);
    step();
    check_eq("op1.mode_after",   32'(jtag_mode),   'h1);
    check_eq("op1.intest_after", 32'(jtag_intest), 'h0);
    step();
    step();
    check_eq("op1.rx_hold", 32'(rx_data), 'h6);

    // start held high through the whole operation.
    run_op(4'b0011, 4'b1100, 1'b0, 1'b0, 1'b1, 0);
    check_eq("hold.done",  32'(done_pat), 32'(ExpDone));
    check_eq("hold.busy",  32'(busy_pat), 32'(ExpBusy));
    step();
    check_eq("hold.idle_gap_busy", 32'(busy), 'h0);
    check_eq("hold.idle_gap_done", 32'(done), 'h0);
    step();
    check_eq("hold.second_busy", 32'(busy), 'h1);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check_eq("hold.second_latency", 32'(k),       'd11);
    check_eq("hold.rx",             32'(rx_data), 'hC);
    check_eq("hold.chain",          32'(cells),   'h3);
    step();

    // Reset during SHIFT slot 2, cycle A (cycle 7).
    tx_data = 4'b1110;
    cap_val = 4'b0101;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_eq("midrst.pre_scanen",  32'(jtag_tx_scanen), 'h1);
    check_eq("midrst.pre_tx_scan", 32'(jtag_tx_scan),   'h1);
    rst = 1'b1;
    #1;
    check_eq("midrst.busy",    32'(busy),           'h0);
    check_eq("midrst.scanen",  32'(jtag_tx_scanen), 'h0);
    check_eq("midrst.clkdr",   32'(jtag_clkdr),     'h0);
    check_eq("midrst.tx_scan", 32'(jtag_tx_scan),   'h0);
    check_eq("midrst.mode",    32'(jtag_mode),      'h0);
    check_eq("midrst.rx",      32'(rx_data),        'h0);
    check_eq("midrst.rstb",    32'(jtag_rstb),      'h1);
    #2 rst = 1'b0;
    step();
    run_op(4'b0101, 4'b1001, 1'b0, 1'b0, 1'b0, 0);
    check_timing("postrst");
    check_eq("postrst.tx_slots", 32'(tx_seen), 'h5);
    check_eq("postrst.rx",       32'(rx_data), 'h9);
    check_eq("postrst.chain",    32'(cells),   'h5);
    step();

    // INTEST, then release two cycles after done.
    run_op(4'b1100, 4'b0011, 1'b1, 1'b0, 1'b0, 0);
    check_eq("intest.done", 32'(done_pat), 32'(ExpDone));
    check_eq("intest.rx",   32'(rx_data),  'h3);
    step();
    check_eq("intest.mode_c13",   32'(jtag_mode),   'h1);
    check_eq("intest.intest_c13", 32'(jtag_intest), 'h1);
    step();
    release_req = 1'b1;
    check_eq("intest.mode_c14",   32'(jtag_mode),   'h1);
    check_eq("intest.intest_c14", 32'(jtag_intest), 'h1);
    step();
    release_req = 1'b0;
    check_eq("intest.mode_rel",   32'(jtag_mode),   'h0);
    check_eq("intest.intest_rel", 32'(jtag_intest), 'h0);

    // start and release together: start wins.
    run_op(4'b0110, 4'b1111, 1'b0, 1'b1, 1'b0, 0);
    check_eq("startrel.mode_c1", 32'(mode_c1),  'h1);
    check_eq("startrel.done",    32'(done_pat), 32'(ExpDone));
    check_eq("startrel.rx",      32'(rx_data),  'hF);
    step();
    check_eq("startrel.mode_after", 32'(jtag_mode), 'h1);

    // TAP reset override applied mid-operation.
    run_op(4'b1001, 4'b1010, 1'b0, 1'b0, 1'b0, 5);
    check_timing("ovr");
    check_eq("ovr.rstb_en", 32'(rbe_pat),  32'(ExpRbeOvr));
    check_eq("ovr.rstb",    32'(rstb_pat), 32'(ExpRstOvr));
    check_eq("ovr.rx",      32'(rx_data),  'hA);
    rst_ovr_en  = 1'b0;
    rst_ovr_val = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
